tensor_core_mma_seq: RTL

- Sequencer that computes a full 4x4 FP16 matrix multiply-accumulate, D = A x B + C, on one shared dot-product MMA unit.
- The unit computes one element per issue: dot(row, column) + c.
- The block latches the A, B and C operands, then issues all 16 (i,j) element jobs to the unit in row-major order.
- It collects each returned element into D and presents D on a valid/ready result port.
- It sits between the tensor-core command front end and the dot-product MMA datapath.

---
 rtl/tensor_core_mma_seq.sv | 118 +++++++++++
 1 files changed

// File: rtl/tensor_core_mma_seq.sv
// Sequences a 4x4 D = A x B + C through one shared dot-product unit, one (i,j) element per cycle.
// Operands are latched on command acceptance; results land in D via a (valid, idx) tag pipe.
module tensor_core_mma_seq #(
  parameter int DWIDTH = 16,
  parameter int DP_LAT = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [16*DWIDTH-1:0]  a_mat,
  input  logic [16*DWIDTH-1:0]  b_mat,
  input  logic [16*DWIDTH-1:0]  c_mat,
  output logic [4*DWIDTH-1:0]   dp_a_row,
  output logic [4*DWIDTH-1:0]   dp_b_col,
  output logic [DWIDTH-1:0]     dp_c_in,
  output logic                  dp_issue,
  input  logic [DWIDTH-1:0]     dp_c_out,
  output logic                  d_valid,
  input  logic                  d_ready,
  output logic [16*DWIDTH-1:0]  d_mat,
  output logic                  busy
);

  localparam int PL = (DP_LAT > 0) ? DP_LAT : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                r_state, w_next;
  logic [3:0]            r_idx;
  logic [16*DWIDTH-1:0]  r_a, r_b, r_c, r_d;
  logic [PL-1:0]         r_tag_vld;
  logic [PL-1:0][3:0]    r_tag_idx;
  logic [1:0]            w_i, w_j;
  logic                  w_drain_done;
  logic                  w_cap;
  logic [3:0]            w_cap_idx;

  assign w_i         = r_idx[3:2];
  assign w_j         = r_idx[1:0];
  assign start_ready = (r_state == S_IDLE);
  assign dp_issue    = (r_state == S_ISSUE);
  assign d_valid     = (r_state == S_DONE);
  assign busy        = (r_state != S_IDLE);
  assign d_mat       = r_d;

  // A combinational unit returns in the issue cycle; otherwise the oldest tag owns dp_c_out.
  assign w_cap     = (DP_LAT == 0) ? dp_issue : r_tag_vld[PL-1];
  assign w_cap_idx = (DP_LAT == 0) ? r_idx    : r_tag_idx[PL-1];

  // Drain ends when only the last stage still holds a tag (it captures this cycle).
  always_comb begin
    w_drain_done = 1'b1;
    for (int k = 0; k < PL - 1; k++)
      if (r_tag_vld[k]) w_drain_done = 1'b0;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start_valid) w_next = S_ISSUE;
      S_ISSUE: if (r_idx == 4'd15) w_next = (DP_LAT > 0) ? S_DRAIN : S_DONE;
      S_DRAIN: if (w_drain_done) w_next = S_DONE;
      S_DONE:  if (d_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    dp_a_row = '0;
    dp_b_col = '0;
    dp_c_in  = '0;
    if (dp_issue) begin
      for (int k = 0; k < 4; k++) begin
        dp_a_row[k*DWIDTH +: DWIDTH] = r_a[(int'(w_i)*4 + k)*DWIDTH +: DWIDTH];
        dp_b_col[k*DWIDTH +: DWIDTH] = r_b[(k*4 + int'(w_j))*DWIDTH +: DWIDTH];
      end
      dp_c_in = r_c[int'(r_idx)*DWIDTH +: DWIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= 4'd0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_d     <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start_valid) begin
        r_a   <= a_mat;
        r_b   <= b_mat;
        r_c   <= c_mat;
        r_idx <= 4'd0;
      end else if (r_state == S_ISSUE) begin
        r_idx <= r_idx + 4'd1;
      end
      if (w_cap) r_d[int'(w_cap_idx)*DWIDTH +: DWIDTH] <= dp_c_out;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tag_vld <= '0;
      r_tag_idx <= '0;
    end else begin
      r_tag_vld[0] <= dp_issue;
      r_tag_idx[0] <= r_idx;
      for (int k = 1; k < PL; k++) begin
        r_tag_vld[k] <= r_tag_vld[k-1];
        r_tag_idx[k] <= r_tag_idx[k-1];
      end
    end
  end

endmodule
